// File: rtl/lpddr2_mem_arbiter.sv
// lpddr2_mem_arbiter: round-robin N-port arbiter onto one LPDDR2 Avalon-MM port; optional read watchdog under MEM_TIMEOUT_EN.
// Latency: write req->done 3 cycles, read req->done 3 + readdatavalid latency; one transaction in flight.
// Backpressure: command held on Avalon until avl_waitrequest_n; requesters hold req until their done pulse.
module lpddr2_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DW         = 32,
    parameter int IN_AW      = 32,
    parameter int AVL_AW     = 27,
    parameter int ADDR_SHIFT = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       iCLK,
    input  logic                       iRST_n,
    input  logic [NUM_PORTS-1:0]       read_req,
    input  logic [NUM_PORTS-1:0]       write_req,
    input  logic [NUM_PORTS*IN_AW-1:0] addr,
    input  logic [NUM_PORTS*DW-1:0]    inData,
    output logic [DW-1:0]              outData,
    output logic [NUM_PORTS-1:0]       done,
    output logic [NUM_PORTS-1:0]       err,
    input  logic                       local_init_done,
    input  logic                       avl_waitrequest_n,
    output logic [AVL_AW-1:0]          avl_address,
    output logic [DW-1:0]              avl_writedata,
    output logic                       avl_read,
    output logic                       avl_write,
    output logic                       avl_burstbegin,
    input  logic                       avl_readdatavalid,
    input  logic [DW-1:0]              avl_readdata,
    output logic [3:0]                 c_state
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [3:0] S_INIT = 4'd0;
    localparam logic [3:0] S_IDLE = 4'd1;
    localparam logic [3:0] S_WR   = 4'd2;
    localparam logic [3:0] S_RD   = 4'd3;
    localparam logic [3:0] S_RDW  = 4'd4;
    localparam logic [3:0] S_DONE = 4'd5;

    logic [3:0]           r_state;
    logic [PW-1:0]        r_rr;
    logic [PW-1:0]        r_grant;
    logic [AVL_AW-1:0]    r_avl_address;
    logic [DW-1:0]        r_avl_writedata;
    logic                 r_avl_read;
    logic                 r_avl_write;
    logic                 r_avl_burstbegin;
    logic [DW-1:0]        r_outData;

    logic [NUM_PORTS-1:0] w_pend;
    logic                 w_found;
    logic [PW-1:0]        w_sel;

    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    // First pending port at or after the round-robin pointer.
    always_comb begin
        w_pend  = read_req | write_req;
        w_found = 1'b0;
        w_sel   = r_rr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && w_pend[f_wrap(r_rr, k)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap(r_rr, k);
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_drop;
    logic          r_err;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state          <= S_INIT;
            r_rr             <= '0;
            r_grant          <= '0;
            r_avl_address    <= '0;
            r_avl_writedata  <= '0;
            r_avl_read       <= 1'b0;
            r_avl_write      <= 1'b0;
            r_avl_burstbegin <= 1'b0;
            r_outData        <= '0;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt         <= '0;
            r_drop           <= 1'b0;
            r_err            <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            if (avl_readdatavalid && r_drop) r_drop <= 1'b0;
`endif
            case (r_state)
                S_INIT: if (local_init_done) r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_found) begin
                        r_grant         <= w_sel;
                        r_rr            <= f_wrap(w_sel, 1);
                        r_avl_address   <= addr[w_sel*IN_AW + ADDR_SHIFT +: AVL_AW];
                        r_avl_writedata <= inData[w_sel*DW +: DW];
                        r_state         <= write_req[w_sel] ? S_WR : S_RD;
                    end
                end
                // First cycle raises the command; burstbegin never outlives it.
                S_WR, S_RD: begin
                    if (!(r_avl_write || r_avl_read)) begin
                        r_avl_write      <= (r_state == S_WR);
                        r_avl_read       <= (r_state == S_RD);
                        r_avl_burstbegin <= 1'b1;
                    end else begin
                        r_avl_burstbegin <= 1'b0;
                        if (avl_waitrequest_n) begin
                            r_avl_write <= 1'b0;
                            r_avl_read  <= 1'b0;
                            r_state     <= (r_state == S_WR) ? S_DONE : S_RDW;
`ifdef MEM_TIMEOUT_EN
                            r_to_cnt    <= '0;
`endif
                        end
                    end
                end
                S_RDW: begin
`ifdef MEM_TIMEOUT_EN
                    if (avl_readdatavalid && !r_drop) begin
                        r_outData <= avl_readdata;
                        r_state   <= S_DONE;
                    end else if (r_to_cnt == TW'(TIMEOUT - 2)) begin
                        r_outData <= DW'(32'hDEADBEEF);
                        r_err     <= 1'b1;
                        r_drop    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_to_cnt  <= r_to_cnt + 1'b1;
                    end
`else
                    if (avl_readdatavalid) begin
                        r_outData <= avl_readdata;
                        r_state   <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (r_state == S_DONE) done[r_grant] = 1'b1;
    end

`ifdef MEM_TIMEOUT_EN
    always_comb begin
        err = '0;
        if (r_state == S_DONE && r_err) err[r_grant] = 1'b1;
    end
`else
    assign err = '0;
`endif

    assign outData        = r_outData;
    assign avl_address    = r_avl_address;
    assign avl_writedata  = r_avl_writedata;
    assign avl_read       = r_avl_read;
    assign avl_write      = r_avl_write;
    assign avl_burstbegin = r_avl_burstbegin;
    assign c_state        = r_state;
endmodule

// File: tb/tb_lpddr2_mem_arbiter.sv
// Bench for lpddr2_mem_arbiter: directed scenarios plus randomized traffic against a
// round-robin/memory reference model, with a simple Avalon slave stub.
module tb_lpddr2_mem_arbiter;
    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   read_req, write_req;
    logic [NP*32-1:0] addr, inData;
    logic [31:0]     outData;
    logic [NP-1:0]   done, err;
    logic            lid, wrn, rdv;
    logic [26:0]     avl_address;
    logic [31:0]     avl_writedata, rdata;
    logic            avl_read, avl_write, bb;
    logic [3:0]      c_state;

    lpddr2_mem_arbiter #(.NUM_PORTS(NP), .DW(32), .IN_AW(32), .AVL_AW(27),
                         .ADDR_SHIFT(0), .TIMEOUT(16)) dut (
        .iCLK(clk), .iRST_n(rst_n), .read_req(read_req), .write_req(write_req),
        .addr(addr), .inData(inData), .outData(outData), .done(done), .err(err),
        .local_init_done(lid), .avl_waitrequest_n(wrn), .avl_address(avl_address),
        .avl_writedata(avl_writedata), .avl_read(avl_read), .avl_write(avl_write),
        .avl_burstbegin(bb), .avl_readdatavalid(rdv), .avl_readdata(rdata),
        .c_state(c_state));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Avalon slave stub
    int          cfg_stall = 0;
    int          cfg_lat   = 1;
    bit          cfg_no_rdv = 0;
    int          stall_left = 0;
    int          rd_cnt = 0;
    bit          rd_pend = 0;
    logic [31:0] rd_val;
    logic [31:0] slave_mem [logic [26:0]];
    logic [26:0] last_acc_addr;
    logic [31:0] last_acc_data;
    bit          last_acc_wr;

    // Reference model state
    logic [31:0] model_mem [logic [26:0]];
    int          model_rr = 0;
    bit          act [NP];
    bit          iswr [NP];
    logic [26:0] ra [NP];
    logic [31:0] rd [NP];

    function automatic logic [31:0] fill(input logic [26:0] a);
        return ({5'b0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] model_read(input logic [26:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return fill(a);
    endfunction

    function automatic int pick_next(input int rr);
        for (int k = 0; k < NP; k++)
            if (act[(rr + k) % NP]) return (rr + k) % NP;
        return -1;
    endfunction

    initial begin
        wrn = 1'b1; rdv = 1'b0; rdata = '0; rd_val = '0;
        forever begin
            @(negedge clk);
            rdv = 1'b0;
            if (!rst_n) begin
                rd_pend = 0; stall_left = cfg_stall; wrn = 1'b1;
            end else begin
                if (rd_pend) begin
                    rd_cnt--;
                    if (rd_cnt <= 0) begin
                        rd_pend = 0;
                        if (!cfg_no_rdv) begin rdv = 1'b1; rdata = rd_val; end
                    end
                end
                if (avl_read || avl_write) begin
                    if (stall_left > 0) begin
                        wrn = 1'b0; stall_left--;
                    end else begin
                        wrn = 1'b1;
                        last_acc_addr = avl_address;
                        last_acc_data = avl_writedata;
                        last_acc_wr   = avl_write;
                        if (avl_write) slave_mem[avl_address] = avl_writedata;
                        else begin
                            rd_pend = 1; rd_cnt = cfg_lat;
                            rd_val = slave_mem.exists(avl_address) ? slave_mem[avl_address] : fill(avl_address);
                        end
                    end
                end else begin
                    wrn = 1'b1; stall_left = cfg_stall;
                end
            end
        end
    end

    task automatic issue(input int p, input bit wr, input bit both, input logic [26:0] a, input logic [31:0] d);
        write_req[p] = wr;
        read_req[p]  = !wr || both;
        addr[p*32 +: 32]   = {5'b0, a};
        inData[p*32 +: 32] = d;
        act[p] = 1; iswr[p] = wr; ra[p] = a; rd[p] = d;
    endtask

    task automatic drop(input int p);
        read_req[p] = 1'b0; write_req[p] = 1'b0; act[p] = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done !== '0) begin seen = 1; break; end
        end
    endtask

    task automatic do_reset();
        bit ok;
        rst_n = 1'b0; lid = 1'b0;
        for (int p = 0; p < NP; p++) drop(p);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lid = 1'b1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (c_state === 4'd1) begin ok = 1; break; end
        end
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL reset_to_idle c_state=%0d want 1", c_state); end
        model_rr = 0;
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0; lid = 1'b0; read_req = '0; write_req = '0; addr = '0; inData = '0;
        for (int p = 0; p < NP; p++) act[p] = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (outData !== 32'h0 || err !== '0 || avl_address !== '0 || avl_writedata !== '0) begin
            n_bad++; $display("FAIL reset_outputs outData=%h err=%b addr=%h", outData, err, avl_address);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_state !== 4'd0 || avl_read !== 1'b0 || avl_write !== 1'b0 || bb !== 1'b0 || done !== '0) bad = 1;
        end
        n_vec++;
        if (bad) begin n_bad++; $display("FAIL init_hold c_state=%0d rd=%b wr=%b bb=%b want 0", c_state, avl_read, avl_write, bb); end
        lid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (c_state !== 4'd1) begin n_bad++; $display("FAIL init_to_idle c_state=%0d want 1", c_state); end
        model_rr = 0;
    endtask

    task automatic test_write();
        int wcnt = 0;
        issue(0, 1, 0, 27'h10, 32'hCAFEF00D);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (avl_write) wcnt++;
            n_vec++;
            if (done !== ((c == 3) ? 3'b001 : 3'b000)) begin
                n_bad++; $display("FAIL write_latency cycle=%0d done=%b", c, done);
            end
        end
        drop(0);
        model_mem[27'h10] = 32'hCAFEF00D;
        model_rr = 1;
        n_vec++;
        if (wcnt != 1 || last_acc_addr !== 27'h10 || last_acc_data !== 32'hCAFEF00D || !last_acc_wr) begin
            n_bad++; $display("FAIL write_cmd wcycles=%0d addr=%h data=%h want 1/10/cafef00d", wcnt, last_acc_addr, last_acc_data);
        end
        @(negedge clk);
        n_vec++;
        if (c_state !== 4'd1 || done !== '0) begin n_bad++; $display("FAIL write_back_idle c_state=%0d done=%b", c_state, done); end
    endtask

    task automatic test_read();
        cfg_lat = 6;
        slave_mem[27'h20] = 32'h12345678;
        model_mem[27'h20] = 32'h12345678;
        issue(1, 0, 0, 27'h20, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_vec++;
            if (done !== ((c == 9) ? 3'b010 : 3'b000)) begin
                n_bad++; $display("FAIL read_latency cycle=%0d done=%b", c, done);
            end
        end
        drop(1);
        model_rr = 2;
        n_vec++;
        if (outData !== 32'h12345678) begin n_bad++; $display("FAIL read_data got %h want 12345678", outData); end
        cfg_lat = 1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit seen;
        int e;
        logic [NP-1:0] expv;
        do_reset();
        for (int p = 0; p < NP; p++) issue(p, 1, 0, 27'h40 + 27'(p), 32'hA000_0000 + 32'(p));
        for (int t = 0; t < 4; t++) begin
            e = pick_next(model_rr);
            wait_done(40, seen);
            expv = '0; expv[e] = 1'b1;
            n_vec++;
            if (!seen || done !== expv) begin
                n_bad++; $display("FAIL rr_order step=%0d done=%b want %b", t, done, expv);
            end
            model_mem[ra[e]] = rd[e];
            model_rr = (e + 1) % NP;
        end
        for (int p = 0; p < NP; p++) drop(p);
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit seen = 0, bb_bad = 0, a_bad = 0;
        int wcnt = 0, bcnt = 0;
        cfg_stall = 5;
        issue(2, 1, 0, 27'h33, 32'h0BAD_F00D);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (avl_write) begin
                wcnt++;
                if (avl_address !== 27'h33) a_bad = 1;
            end
            if (bb) begin
                bcnt++;
                if (wcnt != 1) bb_bad = 1;
            end
            if (done !== '0) begin seen = 1; break; end
        end
        drop(2);
        model_mem[27'h33] = 32'h0BAD_F00D;
        model_rr = 0;
        cfg_stall = 0;
        n_vec++;
        if (!seen || done !== 3'b100) begin n_bad++; $display("FAIL stall_done done=%b want 100", done); end
        n_vec++;
        if (wcnt != 6 || bcnt != 1 || bb_bad || a_bad) begin
            n_bad++; $display("FAIL stall_cmd write_cycles=%0d burst_cycles=%0d want 6/1 bb_late=%0d addr_moved=%0d", wcnt, bcnt, bb_bad, a_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_random_traffic();
        bit seen;
        int e, op;
        logic [NP-1:0] expv;
        for (int p = 0; p < NP; p++) begin
            op = $urandom_range(0, 2);
            issue(p, op != 0, op == 2, 27'h10 + 27'($urandom_range(0, 15)), $urandom);
        end
        for (int t = 0; t < 40; t++) begin
            e = pick_next(model_rr);
            wait_done(100, seen);
            n_vec++;
            if (!seen) begin
                n_bad++; $display("FAIL rand_timeout step=%0d", t);
                break;
            end
            expv = '0; expv[e] = 1'b1;
            n_vec++;
            if (done !== expv || err !== '0) begin
                n_bad++; $display("FAIL rand_grant step=%0d done=%b err=%b want %b", t, done, err, expv);
            end
            if (iswr[e]) begin
                model_mem[ra[e]] = rd[e];
                n_vec++;
                if (!last_acc_wr || last_acc_addr !== ra[e] || last_acc_data !== rd[e]) begin
                    n_bad++; $display("FAIL rand_write step=%0d addr=%h data=%h want %h/%h", t, last_acc_addr, last_acc_data, ra[e], rd[e]);
                end
            end else begin
                n_vec++;
                if (outData !== model_read(ra[e]) || last_acc_addr !== ra[e]) begin
                    n_bad++; $display("FAIL rand_read step=%0d data=%h want %h", t, outData, model_read(ra[e]));
                end
            end
            drop(e);
            model_rr = (e + 1) % NP;
            for (int p = 0; p < NP; p++) begin
                if (p != e && !act[p] && $urandom_range(0, 1) == 1) begin
                    op = $urandom_range(0, 2);
                    issue(p, op != 0, op == 2, 27'h10 + 27'($urandom_range(0, 15)), $urandom);
                end
            end
            if (pick_next(0) < 0) issue((e + 1) % NP, 0, 0, 27'h10 + 27'($urandom_range(0, 15)), 32'h0);
            cfg_stall = $urandom_range(0, 2);
            cfg_lat   = $urandom_range(1, 4);
        end
        for (int p = 0; p < NP; p++) drop(p);
        cfg_stall = 0; cfg_lat = 1;
        repeat (8) @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        bit ok = 0, early = 0;
        do_reset();
        cfg_no_rdv = 1;
        issue(1, 0, 0, 27'h5, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_state === 4'd4) begin ok = 1; break; end
        end
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL timeout_reach_rdw c_state=%0d", c_state); end
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            if (c < 16 && done !== '0) early = 1;
        end
        n_vec++;
        if (early || done !== 3'b010 || err !== 3'b010 || outData !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL timeout_done early=%0d done=%b err=%b data=%h want 010/010/deadbeef", early, done, err, outData);
        end
        drop(1);
        cfg_no_rdv = 0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        bit ok = 0;
        cfg_stall = 20;
        issue(0, 0, 0, 27'h12, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avl_read) begin ok = 1; break; end
        end
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL midreset_no_read avl_read=%b", avl_read); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (avl_read !== 1'b0 || c_state !== 4'd0 || done !== '0) begin
            n_bad++; $display("FAIL midreset_async avl_read=%b c_state=%0d done=%b want 0/0/0", avl_read, c_state, done);
        end
        cfg_stall = 0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_stall();
        test_random_traffic();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
